// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared op-codes, FSM state encoding and width default for
//               the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

  localparam int MD_DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

endpackage : muldiv_unit_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration: shift-add multiply or restoring
//               divide over a shared 2*DATA_W accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic                  is_div,
  input  logic [2*DATA_W-1:0]   acc_in,
  input  logic [DATA_W-1:0]     opnd,
  output logic [2*DATA_W-1:0]   acc_out
);

  // Multiply: upper half accumulates, lower half holds remaining multiplier bits
  logic [DATA_W:0]     w_mul_sum;
  logic [2*DATA_W-1:0] w_mul_acc;

  assign w_mul_sum = {1'b0, acc_in[2*DATA_W-1:DATA_W]}
                   + (acc_in[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
  assign w_mul_acc = {w_mul_sum, acc_in[DATA_W-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in
  logic [DATA_W:0]     w_shift;
  logic [DATA_W:0]     w_diff;
  logic                w_qbit;
  logic [DATA_W-1:0]   w_rem_next;
  logic [2*DATA_W-1:0] w_div_acc;

  assign w_shift    = acc_in[2*DATA_W-1:DATA_W-1];
  assign w_diff     = w_shift - {1'b0, opnd};
  assign w_qbit     = ~w_diff[DATA_W];
  assign w_rem_next = w_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
  assign w_div_acc  = {w_rem_next, acc_in[DATA_W-2:0], w_qbit};

  assign acc_out = is_div ? w_div_acc : w_mul_acc;

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MULT/DIV sequencer owning HI/LO, with stall and
//               flush handling for the EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int                DATA_W  = MD_DATA_W,
  parameter logic [DATA_W-1:0] DIV0_LO = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic              read_req,
  input  logic              cancel,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int              CW       = $clog2(DATA_W);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DATA_W - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [CW-1:0]       r_count;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_opnd;
  logic [DATA_W-1:0]   r_dividend;
  logic                r_is_div;
  logic                r_neg_main;
  logic                r_neg_rem;
  logic                r_div0;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_busy;
  logic                r_done;

  logic                w_accept;
  logic                w_is_muldiv;
  logic                w_signed;
  logic                w_div_op;
  logic [DATA_W-1:0]   w_mag1;
  logic [DATA_W-1:0]   w_mag2;
  logic                w_load;
  logic                w_mt_hi;
  logic                w_mt_lo;
  logic                w_step_en;
  logic                w_commit;
  logic [2*DATA_W-1:0] w_step_acc;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;

  assign w_accept    = start & ~cancel;
  assign w_is_muldiv = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign w_signed    = (op == OP_MULT) | (op == OP_DIV);
  assign w_div_op    = (op == OP_DIV) | (op == OP_DIVU);
  assign w_mag1      = (w_signed & in1[DATA_W-1]) ? ('0 - in1) : in1;
  assign w_mag2      = (w_signed & in2[DATA_W-1]) ? ('0 - in2) : in2;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_load) w_next_state = S_RUN;
      S_RUN: begin
        if (cancel)                    w_next_state = S_IDLE;
        else if (r_count == LAST_CNT)  w_next_state = S_FIX;
      end
      S_FIX:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_load    = 1'b0;
    w_mt_hi   = 1'b0;
    w_mt_lo   = 1'b0;
    w_step_en = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load  = w_accept & w_is_muldiv;
        w_mt_hi = w_accept & (op == OP_MTHI);
        w_mt_lo = w_accept & (op == OP_MTLO);
      end
      S_RUN:   w_step_en = ~cancel;
      S_FIX:   w_commit  = ~cancel;
      default: ;
    endcase
  end

  muldiv_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .is_div  (r_is_div),
    .acc_in  (r_acc),
    .opnd    (r_opnd),
    .acc_out (w_step_acc)
  );

  // Operand capture and iteration datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_dividend <= '0;
      r_is_div   <= 1'b0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div0     <= 1'b0;
    end else if (w_load) begin
      r_count    <= '0;
      r_acc      <= {{DATA_W{1'b0}}, (w_div_op ? w_mag1 : w_mag2)};
      r_opnd     <= w_div_op ? w_mag2 : w_mag1;
      r_dividend <= in1;
      r_is_div   <= w_div_op;
      r_neg_main <= w_signed & (in1[DATA_W-1] ^ in2[DATA_W-1]);
      r_neg_rem  <= w_signed & in1[DATA_W-1];
      r_div0     <= w_div_op & (in2 == '0);
    end else if (w_step_en) begin
      r_count <= r_count + 1'b1;
      r_acc   <= w_step_acc;
    end
  end

  // Sign correction of the magnitude result
  assign w_prod = r_neg_main ? ('0 - r_acc) : r_acc;
  assign w_quo  = r_neg_main ? ('0 - r_acc[DATA_W-1:0]) : r_acc[DATA_W-1:0];
  assign w_rem  = r_neg_rem  ? ('0 - r_acc[2*DATA_W-1:DATA_W]) : r_acc[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state != S_IDLE);
      r_done <= w_commit;
      if (w_commit) begin
        if (r_is_div) begin
          r_lo <= r_div0 ? DIV0_LO    : w_quo;
          r_hi <= r_div0 ? r_dividend : w_rem;
        end else begin
          r_hi <= w_prod[2*DATA_W-1:DATA_W];
          r_lo <= w_prod[DATA_W-1:0];
        end
      end else begin
        if (w_mt_hi) r_hi <= in1;
        if (w_mt_lo) r_lo <= in1;
      end
    end
  end

  assign busy  = r_busy;
  assign stall = r_busy & (start | read_req);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        read_req;
  logic        cancel;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .in1      (in1),
    .in2      (in2),
    .read_req (read_req),
    .cancel   (cancel),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  // Present one op for one clock edge; returns at the negedge after that edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    @(negedge clk);
    op = o; in1 = a; in2 = b; start = 1'b1; cancel = c;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
  endtask

  // Counts busy cycles (bounded) and records whether stall stayed high throughout
  task automatic wait_idle(output int cyc, output logic stall_all);
    cyc = 0;
    stall_all = 1'b1;
    while (busy === 1'b1 && cyc < 200) begin
      if (stall !== 1'b1) stall_all = 1'b0;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
    reset = 1'b0;
  endtask

  task automatic test_multu_max();
    int cyc; logic sa;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_idle(cyc, sa);
    n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 33", cyc); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL multu_done: got %b want 1", done); end
    n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    n_cmp++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_mult_stall();
    int cyc; logic sa;
    issue(3'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
    read_req = 1'b1;
    wait_idle(cyc, sa);
    n_cmp++; if (sa !== 1'b1) begin n_fail++; $display("FAIL mult_stall_held: got %b want 1", sa); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mult_stall_release: got %b want 0", stall); end
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin n_fail++; $display("FAIL mult_neg: got %h want ffffffffffffffeb", {hi, lo}); end
    read_req = 1'b0;
  endtask

  task automatic test_divide();
    int cyc; logic sa;
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(cyc, sa);
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_fail++; $display("FAIL div_neg7_2: got %h want fffffffffffffffd", {hi, lo}); end
    issue(3'd3, 32'd7, 32'd0, 1'b0);
    wait_idle(cyc, sa);
    n_cmp++; if ({hi, lo} !== 64'h00000007_FFFFFFFF) begin n_fail++; $display("FAIL divu_by_zero: got %h want 00000007ffffffff", {hi, lo}); end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle(cyc, sa);
    n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL div_ovf_cycles: got %0d want 33", cyc); end
    n_cmp++; if ({hi, lo} !== 64'h00000000_80000000) begin n_fail++; $display("FAIL div_overflow: got %h want 0000000080000000", {hi, lo}); end
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    wait_idle(cyc, sa);
    n_cmp++; if ({hi, lo} !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL divu_100_7: got %h want 000000020000000e", {hi, lo}); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic sa;
    issue(3'd1, 32'd6, 32'd9, 1'b0);
    repeat (4) @(negedge clk);
    op = 3'd5; in1 = 32'hDEADBEEF; start = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL busy_start_stall: got %b want 1", stall); end
    @(negedge clk);
    start = 1'b0;
    wait_idle(cyc, sa);
    n_cmp++; if ({hi, lo} !== 64'h00000000_00000036) begin n_fail++; $display("FAIL busy_start_ignored: got %h want 0000000000000036", {hi, lo}); end
  endtask

  task automatic test_mt_cancel();
    int cyc; logic sa;
    issue(3'd4, 32'h12345678, 32'd0, 1'b0);
    n_cmp++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mthi_value: got %h want 12345678", hi); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL mthi_busy_done: got %b want 00", {busy, done}); end
    issue(3'd5, 32'hCAFEF00D, 32'd0, 1'b0);
    n_cmp++; if (lo !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mtlo_value: got %h want cafef00d", lo); end
    issue(3'd0, 32'd5, 32'd5, 1'b0);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL cancel_idle: got %b want 00", {busy, done}); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL cancel_no_done: got %b want 0", done); end
    n_cmp++; if ({hi, lo} !== 64'h12345678_CAFEF00D) begin n_fail++; $display("FAIL cancel_hilo: got %h want 12345678cafef00d", {hi, lo}); end
    issue(3'd6, 32'h1111_1111, 32'h2, 1'b0);
    n_cmp++; if ({busy, hi, lo} !== {1'b0, 64'h12345678_CAFEF00D}) begin n_fail++; $display("FAIL unused_op: got %h want 012345678cafef00d", {busy, hi, lo}); end
    wait_idle(cyc, sa);
  endtask

  task automatic test_async_reset();
    issue(3'd0, 32'd3, 32'd4, 1'b0);
    repeat (5) @(negedge clk);
    read_req = 1'b1;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({busy, stall, done} !== 3'b000) begin n_fail++; $display("FAIL async_reset_ctl: got %b want 000", {busy, stall, done}); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL async_reset_hilo: got %h want 0", {hi, lo}); end
    @(negedge clk);
    reset = 1'b0; read_req = 1'b0;
    issue(3'd4, 32'hABCD0000, 32'd0, 1'b1);
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL cancel_mthi: got %h want 0", hi); end
    issue(3'd1, 32'd2, 32'd3, 1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_start: got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if ({busy, done, hi, lo} !== 66'h0) begin n_fail++; $display("FAIL cancel_start_state: got %h want 0", {busy, done, hi, lo}); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; in1 = '0; in2 = '0;
    read_req = 1'b0; cancel = 1'b0;
    test_reset();
    test_multu_max();
    test_mult_stall();
    test_divide();
    test_back_to_back();
    test_mt_cancel();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_muldiv_unit
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide sequencer owning the HI/LO registers; sits beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs multi-cycle ops over 33 cycles.
- Drives a stall request to the hazard unit so that a new muldiv op, or an MFHI/MFLO, waits while the unit is busy.
- Honours pipeline flush by aborting an in-flight operation.

Parameters:
- DATA_W, 32, operand/HI/LO width; only 32 is supported.
- DIV0_LO, 32'hFFFFFFFF, LO result for division by zero.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  EX holds a muldiv op this cycle.
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; other values are no-op.
- in1  input  32  rs operand (dividend / multiplicand / MT data).
- in2  input  32  rt operand (divisor / multiplier).
- read_req  input  1  MFHI/MFLO in EX.
- cancel  input  1  pipeline flush of the EX instruction.
- busy  output  1  registered; high while RUN or FIX.
- stall  output  1  combinational: busy & (start | read_req).
- done  output  1  one-cycle registered pulse after a result commits.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset is async and aborts any op.
- States:
  - IDLE: accept start when cancel=0.
  - RUN: 32 iterations, counter counts 0..31.
  - FIX: sign correction and commit, then back to IDLE.
- IDLE, start&~cancel:
  - MTHI/MTLO: hi or lo takes in1 at the clock edge. Stay in IDLE, busy stays 0, no done pulse.
  - MULT/DIV family: latch the magnitudes. Signed ops use |in1| and |in2|; unsigned ops use raw values.
  - Also latch the result signs:
    - Product sign: in1[31]^in2[31].
    - Quotient sign: in1[31]^in2[31].
    - Remainder sign: in1[31].
  - Go to RUN; busy=1 from the next cycle.
- RUN, multiply: shift-add, one multiplier bit per cycle into a 64-bit accumulator.
- RUN, divide: restoring divide, one quotient bit per cycle into a 32-bit remainder and quotient.
- Leave RUN after counter=31.
- FIX:
  - Negate the 64-bit product, or the quotient/remainder, per the latched signs.
  - Write hi/lo at the end of FIX:
    - Multiply: hi=prod[63:32], lo=prod[31:0].
    - Divide: lo=quotient, hi=remainder.
  - Return to IDLE; done=1 for the following cycle only.
- Latency: start at cycle T, busy high T+1..T+33, hi/lo new and done high at T+34.
- Divide by zero: no iteration special-case in RUN. FIX overrides with lo=DIV0_LO, hi=in1 as latched (raw dividend), for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000 (wraps), hi=0.
- start while busy: ignored; the hazard unit holds the instruction via stall.
- cancel while RUN/FIX: go to IDLE next cycle, busy=0, hi/lo unchanged, no done pulse.
- cancel with start in IDLE: cancel wins; nothing latched, and MTHI/MTLO do not write.
- read_req in IDLE: no stall. hi/lo reflect the last commit or MT write (no bypass of the same-cycle MT write).
- Unused op codes: treated as no-op, no state change.

Decomposition:
- Shared package:
  - op-code constants (OP_MULT..OP_MTLO).
  - state encoding (S_IDLE, S_RUN, S_FIX).
  - DATA_W default.
- Sub-module muldiv_step: combinational single iteration for both modes.
  - Multiply: conditional add plus shift.
  - Divide: trial subtract plus quotient bit.
  - Instantiated once inside muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high 33 cycles, done at T+34, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; read_req during busy holds stall=1 until busy drops.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, no hang.
- MTHI 0x12345678 in IDLE -> hi=0x12345678 next cycle, busy=0, no done. Then MULT started, cancel at RUN cycle 10 -> IDLE next cycle, hi still 0x12345678, no done.
- Async reset asserted mid-RUN -> immediately busy=0, stall=0, hi=lo=0, done=0; start+cancel in the same IDLE cycle -> no state change.
